async_fifo_read_ctrl: RTL



---
 rtl/async_fifo_pkg.sv | 23 ++
 rtl/cdc_sync2.sv | 23 ++
 rtl/async_fifo_read_ctrl.sv | 69 ++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for both sides of the async FIFO.
// The Gray/binary converters work on 32-bit vectors; callers zero-extend and truncate.
package async_fifo_pkg;

  localparam int unsigned DEFAULT_SIZE_LOG2 = 5;

  typedef logic [DEFAULT_SIZE_LOG2:0] ptr_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave narrower pointers unaffected.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer with synchronous active-low reset.
module cdc_sync2 #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_sync1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      q       <= '0;
    end else begin
      r_sync1 <= d;
      q       <= r_sync1;
    end
  end

endmodule

// File: rtl/async_fifo_read_ctrl.sv
// Read-domain side of the async FIFO: read pointers, empty/level flags, RAM read address.
// Flags are computed from the next pointer so the last read sets empty on the same edge.
module async_fifo_read_ctrl
  import async_fifo_pkg::*;
#(
  parameter int unsigned SIZE_LOG2           = DEFAULT_SIZE_LOG2,
  parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
  input  logic                 read_clk,
  input  logic                 read_rst_n,
  input  logic                 p_read_en,
  input  logic [SIZE_LOG2:0]   r_write_ptr_gray,
  output logic                 p_read_empty,
  output logic                 p_read_almost_empty,
  output logic                 p_read_underflow,
  output logic [SIZE_LOG2:0]   read_level,
  output logic [SIZE_LOG2-1:0] read_addr,
  output logic [SIZE_LOG2:0]   r_read_ptr_bin,
  output logic [SIZE_LOG2:0]   r_read_ptr_gray
);

  localparam int unsigned PtrW = SIZE_LOG2 + 1;

  logic [PtrW-1:0] w_sync2;
  logic [PtrW-1:0] w_ptr_bin_next;
  logic [PtrW-1:0] w_ptr_gray_next;
  logic [PtrW-1:0] w_level_next;
  logic            w_acc;

  cdc_sync2 #(
    .WIDTH(PtrW)
  ) u_wptr_sync (
    .clk  (read_clk),
    .rst_n(read_rst_n),
    .d    (r_write_ptr_gray),
    .q    (w_sync2)
  );

  always_comb begin
    w_acc           = p_read_en && !p_read_empty;
    w_ptr_bin_next  = r_read_ptr_bin + PtrW'(w_acc);
    w_ptr_gray_next = PtrW'(bin2gray(32'(w_ptr_bin_next)));
    // Modulo subtraction keeps the level correct across the wrap bit.
    w_level_next    = PtrW'(gray2bin(32'(w_sync2))) - w_ptr_bin_next;
  end

  assign read_addr = w_ptr_bin_next[SIZE_LOG2-1:0];

  always_ff @(posedge read_clk) begin
    if (!read_rst_n) begin
      r_read_ptr_bin      <= '0;
      r_read_ptr_gray     <= '0;
      read_level          <= '0;
      p_read_empty        <= 1'b1;
      p_read_almost_empty <= 1'b1;
      p_read_underflow    <= 1'b0;
    end else begin
      r_read_ptr_bin      <= w_ptr_bin_next;
      r_read_ptr_gray     <= w_ptr_gray_next;
      read_level          <= w_level_next;
      p_read_empty        <= (w_ptr_gray_next == w_sync2);
      p_read_almost_empty <= (32'(w_level_next) <= ALMOST_EMPTY_THRESH);
      if (p_read_en && p_read_empty) begin
        p_read_underflow <= 1'b1;
      end
    end
  end

endmodule
